// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receiver: synchronises the serial line, samples each bit at its
// centre with a cycle counter and rebuilds frames into a parallel byte.
// Good frames pulse uart_rx_valid. A low stop bit pulses either uart_rx_break
// (all-zero payload) or uart_rx_frame_err (any other payload).
module uart_rx_deserializer #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_break,
    output logic                    uart_rx_frame_err
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CW             = $clog2(CYCLES_PER_BIT) + 1;
    localparam int IW             = $clog2(PAYLOAD_BITS) + 1;

    localparam logic [CW-1:0] CNT_BIT_END  = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF_END = CW'(HALF_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RECV,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    break_q, break_d;
    logic                    ferr_q, ferr_d;
    logic                    sync1_q;
    logic                    rxd_s_q;

    // Two-flop synchroniser for the asynchronous serial line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rxd_s_q <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            rxd_s_q <= sync1_q;
        end
    end

    // State, counters, shift register and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            break_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            break_q <= break_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: bit-centre sampling and frame classification.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        break_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (uart_rx_en && !rxd_s_q) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF_END) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = '0;
                        state_d = RECV;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            RECV: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d   = '0;
                    // Right shift with the new sample entering at the MSB, so
                    // the first (LSB) bit ends up at bit 0 after the last shift.
                    shift_d = PAYLOAD_BITS'({rxd_s_q, shift_q} >> 1);
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            STOP: begin
                if (cnt_q == CNT_BIT_END) begin
                    cnt_d = '0;
                    if (rxd_s_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else if (shift_q == '0) begin
                        break_d = 1'b1;
                        state_d = WAIT_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            WAIT_IDLE: begin
                cnt_d = '0;
                if (rxd_s_q) begin
                    state_d = IDLE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign uart_rx_data      = data_q;
    assign uart_rx_valid     = valid_q;
    assign uart_rx_break     = break_q;
    assign uart_rx_frame_err = ferr_q;

endmodule
